alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: instr_valid  in  1  instruction offered; instr  in  32  instruction word; instr_ready  out  1  stage can accept.
REQ-004 SHALL have: alu_i1  out  32 / alu_i2  out  32 / alu_sel  out  5  registered operands and selector driving the ALU; alu_o  in  32  ALU result (combinational).
REQ-005 SHALL have: wb_valid  out  1  one-cycle writeback pulse; wb_addr  out  5  destination register; wb_data  out  32  written value; illegal  out  1  one-cycle pulse on undecodable opcode.
REQ-006 SHALL have, only with ISSUE_RETIRE_CNT_EN: retire_cnt  out  32  count of instructions written back.

Function
REQ-007 SHALL decode instr[31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [15:0] imm16.
REQ-008 SHALL map opcodes to alu_sel/operands/destination: 0x00 ADD 10000, I1=R[rs], I2=R[rt], dest rd; 0x01 NOR 10011, same operands, dest rd; 0x02 NOT 00010, I1=0, I2=R[rt], dest rd; 0x03 ROLV 00000, I1=R[rs] (rotate amount), I2=R[rt], dest rd; 0x04 RORV 00001, as ROLV; 0x05 NORI 00111, I1=R[rs], I2=zero-extended imm16, dest rt.
REQ-009 SHALL treat every other opcode as illegal: no register write, illegal pulses one cycle.
REQ-010 SHALL contain a 32x32 register file, R0 reading 0 always; writes to R0 discarded (wb_valid still pulses, wb_data = alu_o).
REQ-011 SHALL use FSM IDLE -> DECODE -> EXEC -> IDLE; instr_ready = (state==IDLE).
REQ-012 IDLE: on edge with instr_valid&instr_ready, latch instr into IR, go DECODE; else stay.
REQ-013 DECODE: read rs/rt, register alu_i1/alu_i2/alu_sel at edge, go EXEC; if illegal, leave ALU regs unchanged, assert illegal next cycle, go IDLE.
REQ-014 EXEC: at edge write alu_o to R[dest], register wb_valid=1, wb_addr=dest, wb_data=alu_o, go IDLE.
REQ-015 Latency: accept at edge N, writeback at edge N+2, wb_valid high cycle after N+2; throughput one instruction per 3 cycles; back-to-back instruction accepted at edge N+3 observes the prior write (no hazard logic).
REQ-016 wb_valid and illegal SHALL be high exactly one cycle; wb_addr/wb_data hold last value otherwise.
REQ-017 instr changes while instr_ready=0 SHALL be ignored.

Reset
REQ-018 reset SHALL force state IDLE, clear IR, all 32 registers, alu_i1/alu_i2=0, alu_sel=00000, wb_valid=0, wb_addr=0, wb_data=0, illegal=0, retire_cnt=0.
REQ-019 reset in DECODE or EXEC SHALL abort the instruction: no register write, no wb_valid; instr_ready=1 the cycle after reset deasserts.
REQ-020 reset SHALL take priority over instr_valid on the same edge.

Configuration
REQ-021 With ISSUE_RETIRE_CNT_EN defined, retire_cnt SHALL increment by 1 on each EXEC edge (illegal excluded), wrapping 0xFFFFFFFF->0; without it, port and counter SHALL be absent and behaviour otherwise identical.

Structure
REQ-022 Package alu_pkg SHALL hold the 5-bit selector constants, 6-bit opcode constants, and FSM state enum.
REQ-023 Register file SHALL be sub-module regfile32 (2 async read ports, 1 sync write port, sync reset clear).

Verification (bench instantiates the team ALU on alu_i1/alu_i2/alu_sel/alu_o)
REQ-024 Reset, then NORI rt=1 rs=0 imm=0xFFF0 -> R1=0xFFFF000F, wb_addr=1, wb_valid one cycle at accept+3.
REQ-025 R1=0x0000000F preloaded via NORI; ADD rd=2 rs=1 rt=1 -> wb_data=0x0000001E, alu_sel=10000 during EXEC.
REQ-026 NOT rd=3 rt=2 after above -> wb_data=0xFFFFFFE1; NOR rd=0 -> wb_valid pulses, R0 still reads 0.
REQ-027 opcode 0x3F -> illegal high one cycle, no wb_valid, registers unchanged, instr_ready back to 1 after 2 cycles.
REQ-028 reset asserted in EXEC of ADD -> no writeback, all outputs 0, next instruction accepted normally; with ISSUE_RETIRE_CNT_EN, 4 legal + 1 illegal instructions -> retire_cnt=4.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue stage: ALU selector codes, opcodes, FSM states and the opcode decoder.
// The optional retire counter in alu_issue is enabled by defining ISSUE_RETIRE_CNT_EN.
package alu_pkg;

    localparam logic [4:0] SEL_ADD  = 5'b10000;
    localparam logic [4:0] SEL_NOR  = 5'b10011;
    localparam logic [4:0] SEL_NOT  = 5'b00010;
    localparam logic [4:0] SEL_ROLV = 5'b00000;
    localparam logic [4:0] SEL_RORV = 5'b00001;
    localparam logic [4:0] SEL_NORI = 5'b00111;

    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_NOR  = 6'h01;
    localparam logic [5:0] OP_NOT  = 6'h02;
    localparam logic [5:0] OP_ROLV = 6'h03;
    localparam logic [5:0] OP_RORV = 6'h04;
    localparam logic [5:0] OP_NORI = 6'h05;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXEC
    } state_t;

    typedef struct packed {
        logic       legal;
        logic [4:0] sel;
        logic       zero_i1;  // operand 1 forced to zero
        logic       imm_i2;   // operand 2 is the zero-extended immediate
        logic       dest_rt;  // result goes to rt instead of rd
    } decode_t;

    function automatic decode_t decode_op(input logic [5:0] op);
        decode_t d;
        d = '{legal: 1'b1, sel: SEL_ADD, zero_i1: 1'b0, imm_i2: 1'b0, dest_rt: 1'b0};
        case (op)
            OP_ADD:  d.sel = SEL_ADD;
            OP_NOR:  d.sel = SEL_NOR;
            OP_NOT:  begin d.sel = SEL_NOT;  d.zero_i1 = 1'b1; end
            OP_ROLV: d.sel = SEL_ROLV;
            OP_RORV: d.sel = SEL_RORV;
            OP_NORI: begin d.sel = SEL_NORI; d.imm_i2 = 1'b1; d.dest_rt = 1'b1; end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/regfile32.sv
// 32 x 32-bit register file: two asynchronous read ports, one synchronous write port.
// Register 0 always reads zero and ignores writes.
module regfile32 (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  raddr_a,
    output logic [31:0] rdata_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_b,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] mem [32];

    // NOTE: resetting every entry prevents mapping to block RAM, but an aborted program must never see stale data.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == 5'd0) ? '0 : mem[raddr_a];
    assign rdata_b = (raddr_b == 5'd0) ? '0 : mem[raddr_b];

endmodule

// File: rtl/alu_issue.sv
// Three-cycle issue stage (IDLE -> DECODE -> EXEC) feeding an external combinational ALU and writing back into regfile32.
// Define ISSUE_RETIRE_CNT_EN to add the retire_cnt output counting written-back instructions.
module alu_issue
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic [31:0] alu_i1,
    output logic [31:0] alu_i2,
    output logic [4:0]  alu_sel,
    input  logic [31:0] alu_o,
    output logic        wb_valid,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        illegal
`ifdef ISSUE_RETIRE_CNT_EN
    ,
    output logic [31:0] retire_cnt
`endif
);

    state_t      state, state_d;
    logic [31:0] ir;
    logic [31:0] rdata_a, rdata_b;
    decode_t     dec;
    logic [4:0]  rs, rt, rd, dest;
    logic [15:0] imm16;

    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign imm16 = ir[15:0];
    assign dec   = decode_op(ir[31:26]);
    assign dest  = dec.dest_rt ? rt : rd;

    assign instr_ready = (state == ST_IDLE);

    regfile32 u_regfile (
        .clk     (clk),
        .reset   (reset),
        .raddr_a (rs),
        .rdata_a (rdata_a),
        .raddr_b (rt),
        .rdata_b (rdata_b),
        .we      (state == ST_EXEC),
        .waddr   (dest),
        .wdata   (alu_o)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // NOTE: next state is defaulted before the case so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:   if (instr_valid) state_d = ST_DECODE;
            ST_DECODE: state_d = dec.legal ? ST_EXEC : ST_IDLE;
            ST_EXEC:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ir       <= '0;
            alu_i1   <= '0;
            alu_i2   <= '0;
            alu_sel  <= '0;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            illegal  <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            illegal  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (instr_valid) ir <= instr;
                end
                ST_DECODE: begin
                    // An illegal opcode leaves the ALU operands untouched.
                    if (dec.legal) begin
                        alu_i1  <= dec.zero_i1 ? '0 : rdata_a;
                        alu_i2  <= dec.imm_i2 ? {16'h0000, imm16} : rdata_b;
                        alu_sel <= dec.sel;
                    end else begin
                        illegal <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    wb_valid <= 1'b1;
                    wb_addr  <= dest;
                    wb_data  <= alu_o;
                end
                default: ;
            endcase
        end
    end

`ifdef ISSUE_RETIRE_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_cnt <= '0;
        end else if (state == ST_EXEC) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural ALU on alu_i1/alu_i2/alu_sel/alu_o.
// Expected values are hand-computed constants; ISSUE_RETIRE_CNT_EN adds the retire count check.
module tb_alu_issue;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [31:0] alu_i1, alu_i2, alu_o;
    logic [4:0]  alu_sel;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        illegal;
`ifdef ISSUE_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    alu_issue dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .alu_i1      (alu_i1),
        .alu_i2      (alu_i2),
        .alu_sel     (alu_sel),
        .alu_o       (alu_o),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .illegal     (illegal)
`ifdef ISSUE_RETIRE_CNT_EN
        ,
        .retire_cnt  (retire_cnt)
`endif
    );

    // Behavioural team ALU: rotates take their amount from alu_i1[4:0].
    logic [63:0] dbl_l, dbl_r;
    always_comb begin
        dbl_l = {alu_i2, alu_i2} << alu_i1[4:0];
        dbl_r = {alu_i2, alu_i2} >> alu_i1[4:0];
        case (alu_sel)
            5'b10000: alu_o = alu_i1 + alu_i2;
            5'b10011: alu_o = ~(alu_i1 | alu_i2);
            5'b00010: alu_o = ~alu_i2;
            5'b00000: alu_o = dbl_l[63:32];
            5'b00001: alu_o = dbl_r[31:0];
            5'b00111: alu_o = ~(alu_i1 | alu_i2);
            default:  alu_o = '0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] r_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd);
        return {op, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    endtask

    // One rising edge, then return at the following falling edge for sampling/driving.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Offer w for one accept edge, then scribble on instr while the stage is busy.
    task automatic send(input string tag, input logic [31:0] w);
        check({tag, " ready"}, 32'(instr_ready), 32'd1);
        instr       = w;
        instr_valid = 1'b1;
        cyc();
        instr_valid = 1'b0;
        instr       = 32'hFC00_0000;
    endtask

    task automatic run_legal(input string tag, input logic [31:0] w, input logic [4:0] sel,
                             input logic [4:0] addr, input logic [31:0] data);
        send(tag, w);
        check({tag, " wb_early"}, 32'(wb_valid), 32'd0);
        cyc();
        check({tag, " sel"}, 32'(alu_sel), 32'(sel));
        check({tag, " wb_pre"}, 32'(wb_valid), 32'd0);
        cyc();
        check({tag, " wb_valid"}, 32'(wb_valid), 32'd1);
        check({tag, " wb_addr"}, 32'(wb_addr), 32'(addr));
        check({tag, " wb_data"}, wb_data, data);
        cyc();
        check({tag, " wb_pulse"}, 32'(wb_valid), 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        @(negedge clk);
        cyc();
        cyc();
        check("rst ready", 32'(instr_ready), 32'd1);
        check("rst wb_valid", 32'(wb_valid), 32'd0);
        check("rst alu_sel", 32'(alu_sel), 32'd0);
        check("rst alu_i1", alu_i1, 32'd0);
        check("rst wb_data", wb_data, 32'd0);
        check("rst illegal", 32'(illegal), 32'd0);
        reset = 1'b0;

        run_legal("nori_r1", i_type(6'h05, 5'd0, 5'd1, 16'hFFF0), 5'b00111, 5'd1, 32'hFFFF_000F);
        run_legal("nori_r4", i_type(6'h05, 5'd0, 5'd4, 16'h000F), 5'b00111, 5'd4, 32'hFFFF_FFF0);
        run_legal("nori_r1b", i_type(6'h05, 5'd4, 5'd1, 16'h0000), 5'b00111, 5'd1, 32'h0000_000F);
        run_legal("add_r2", r_type(6'h00, 5'd1, 5'd1, 5'd2), 5'b10000, 5'd2, 32'h0000_001E);
        run_legal("not_r3", r_type(6'h02, 5'd0, 5'd2, 5'd3), 5'b00010, 5'd3, 32'hFFFF_FFE1);
        check("not i1", alu_i1, 32'd0);
        run_legal("nor_r0", r_type(6'h01, 5'd1, 5'd2, 5'd0), 5'b10011, 5'd0, 32'hFFFF_FFE0);
        run_legal("read_r0", r_type(6'h00, 5'd0, 5'd1, 5'd5), 5'b10000, 5'd5, 32'h0000_000F);
        run_legal("rolv_r6", r_type(6'h03, 5'd1, 5'd2, 5'd6), 5'b00000, 5'd6, 32'h000F_0000);
        run_legal("rorv_r7", r_type(6'h04, 5'd1, 5'd3, 5'd7), 5'b00001, 5'd7, 32'hFFC3_FFFF);

        send("ill", r_type(6'h3F, 5'd1, 5'd2, 5'd8));
        check("ill early", 32'(illegal), 32'd0);
        cyc();
        check("ill pulse", 32'(illegal), 32'd1);
        check("ill no_wb", 32'(wb_valid), 32'd0);
        check("ill ready", 32'(instr_ready), 32'd1);
        check("ill sel_kept", 32'(alu_sel), 32'b00001);
        cyc();
        check("ill one_cycle", 32'(illegal), 32'd0);
        check("ill no_wb2", 32'(wb_valid), 32'd0);
        run_legal("ill r8", r_type(6'h00, 5'd8, 5'd0, 5'd9), 5'b10000, 5'd9, 32'h0000_0000);
        run_legal("ill r1", r_type(6'h00, 5'd1, 5'd0, 5'd9), 5'b10000, 5'd9, 32'h0000_000F);

        send("abort", r_type(6'h00, 5'd1, 5'd1, 5'd2));
        cyc();
        reset = 1'b1;
        cyc();
        check("abort wb_valid", 32'(wb_valid), 32'd0);
        check("abort wb_data", wb_data, 32'd0);
        check("abort wb_addr", 32'(wb_addr), 32'd0);
        check("abort alu_i1", alu_i1, 32'd0);
        check("abort alu_i2", alu_i2, 32'd0);
        check("abort alu_sel", 32'(alu_sel), 32'd0);
        check("abort ready", 32'(instr_ready), 32'd1);
        instr       = i_type(6'h05, 5'd0, 5'd1, 16'h0000);
        instr_valid = 1'b1;
        cyc();
        check("rst_prio ready", 32'(instr_ready), 32'd1);
        instr_valid = 1'b0;
        reset       = 1'b0;
        cyc();
        check("rst_prio idle", 32'(instr_ready), 32'd1);
        check("rst_prio no_wb", 32'(wb_valid), 32'd0);

        run_legal("post_nori", i_type(6'h05, 5'd0, 5'd1, 16'hFFF0), 5'b00111, 5'd1, 32'hFFFF_000F);
        run_legal("post_r2", r_type(6'h00, 5'd2, 5'd0, 5'd9), 5'b10000, 5'd9, 32'h0000_0000);
        run_legal("post_r10", i_type(6'h05, 5'd0, 5'd10, 16'h0000), 5'b00111, 5'd10, 32'hFFFF_FFFF);
        send("post_ill", r_type(6'h2A, 5'd0, 5'd0, 5'd0));
        cyc();
        check("post_ill pulse", 32'(illegal), 32'd1);
        cyc();
        run_legal("post_r11", i_type(6'h05, 5'd10, 5'd11, 16'h0000), 5'b00111, 5'd11, 32'h0000_0000);
`ifdef ISSUE_RETIRE_CNT_EN
        check("retire_cnt", retire_cnt, 32'd4);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
